// File: rtl/multi_code_lock.sv
// Keypad code lock: SLOTS stored BCD user codes, master-code slot programming, inactivity timeout.
// Optional failed-attempt lockout is built when the LOCKOUT_EN macro is defined.
module multi_code_lock #(
  parameter int unsigned                  DIGITS         = 6,
  parameter int unsigned                  SLOTS          = 2,
  parameter logic [4*DIGITS-1:0]          MASTER_CODE    = 24'h999999,
  parameter logic [4*DIGITS*SLOTS-1:0]    INIT_CODES     = {24'h666666, 24'h123456},
  parameter int unsigned                  MAX_FAIL       = 3,
  parameter int unsigned                  LOCKOUT_CYCLES = 24000000,
  parameter int unsigned                  TIMEOUT_CYCLES = 60000000,
  localparam int unsigned                 SW             = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int unsigned                 CW             = $clog2(DIGITS + 2)
) (
  input  logic          hwclk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  output logic          unlock,
  output logic [SW-1:0] hit_slot,
  output logic          fail,
  output logic          locked_out,
  output logic          prog_mode,
  output logic          prog_done,
  output logic [CW-1:0] digit_cnt,
  output logic          ready
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] K_CLEAR = 4'hA;
  localparam logic [3:0] K_ENTER = 4'hB;
  localparam logic [3:0] K_PROG  = 4'hC;

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, RESULT,
`ifdef LOCKOUT_EN
    LOCKOUT,
`endif
    PROG_AUTH, PROG_SEL, PROG_NEW
  } state_e;

  // What the CHECK/RESULT pair is evaluating; every ENTER-style decision goes through it.
  typedef enum logic [1:0] {CK_USER, CK_MASTER, CK_WRITE, CK_ABORT} kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            ok_q, ok_d;
  logic [SW-1:0]   hit_q, hit_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [BW-1:0]   slot_q [SLOTS];
  logic            wr_en;

  logic            key_acc, is_digit, timed, expired, room, len_ok;
  logic [BW-1:0]   psh_buf;
  logic [CW-1:0]   psh_cnt;
  logic            psh_ovf;
  logic            user_hit;
  logic [SW-1:0]   user_idx;

`ifdef LOCKOUT_EN
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LK_LAST = LW'(LOCKOUT_CYCLES - 1);
  logic [FW-1:0]   fcnt_q, fcnt_d, fcnt_inc;
  logic [LW-1:0]   lk_q, lk_d;
  assign fcnt_inc   = fcnt_q + 1'b1;
  assign locked_out = (state_q == LOCKOUT);
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_FAIL, LOCKOUT_CYCLES};
  assign locked_out = 1'b0;
`endif

  assign ready     = (state_q == IDLE) || (state_q == ENTRY) || prog_mode;
  assign prog_mode = (state_q == PROG_AUTH) || (state_q == PROG_SEL) || (state_q == PROG_NEW);
  assign timed     = (state_q == ENTRY) || prog_mode;
  assign key_acc   = key_valid && ready;
  assign is_digit  = (key_code <= 4'd9);
  assign expired   = timed && !key_acc && (tmo_q == TMO_LAST);
  assign len_ok    = (cnt_q == CW'(DIGITS)) && !ovf_q;

  assign room    = (cnt_q < CW'(DIGITS));
  assign psh_buf = room ? {buf_q[BW-5:0], key_code} : buf_q;
  assign psh_cnt = room ? cnt_q + 1'b1 : CW'(DIGITS + 1);
  assign psh_ovf = ovf_q | ~room;

  assign unlock    = (state_q == RESULT) && ok_q && (kind_q == CK_USER);
  assign fail      = (state_q == RESULT) && !ok_q;
  assign prog_done = (state_q == RESULT) && ok_q && (kind_q == CK_WRITE);
  assign hit_slot  = hit_q;
  assign digit_cnt = cnt_q;

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    user_hit = 1'b0;
    user_idx = '0;
    for (int unsigned s = SLOTS; s > 0; s--) begin
      if (buf_q == slot_q[s-1]) begin
        user_hit = 1'b1;
        user_idx = SW'(s - 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ok_d    = ok_q;
    hit_d   = hit_q;
    sel_d   = sel_q;
    wr_en   = 1'b0;
    tmo_d   = '0;
    if (timed && !key_acc) tmo_d = tmo_q + 1'b1;
`ifdef LOCKOUT_EN
    fcnt_d = fcnt_q;
    lk_d   = lk_q;
`endif
    case (state_q)
      IDLE, ENTRY, PROG_AUTH, PROG_NEW: begin
        if (key_acc) begin
          if (is_digit) begin
            buf_d = psh_buf;
            cnt_d = psh_cnt;
            ovf_d = psh_ovf;
            if (state_q == IDLE) state_d = ENTRY;
          end else if (key_code == K_CLEAR) begin
            buf_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
          end else if (key_code == K_ENTER) begin
            state_d = CHECK;
            kind_d  = (state_q == PROG_AUTH) ? CK_MASTER :
                      (state_q == PROG_NEW)  ? CK_WRITE  : CK_USER;
          end else if (key_code == K_PROG && state_q == IDLE) begin
            state_d = PROG_AUTH;
          end
        end
      end
      PROG_SEL: begin
        if (key_acc) begin
          if (is_digit && ({28'd0, key_code} < SLOTS)) begin
            sel_d   = SW'(key_code);
            state_d = PROG_NEW;
          end else if (is_digit || key_code == K_ENTER || key_code == K_PROG) begin
            state_d = CHECK;
            kind_d  = CK_ABORT;
          end else if (key_code == K_CLEAR) begin
            state_d = IDLE;
          end
        end
      end
      CHECK: begin
        case (kind_q)
          CK_USER: begin
            ok_d = len_ok && user_hit;
            if (len_ok && user_hit) hit_d = user_idx;
          end
          CK_MASTER: ok_d = len_ok && (buf_q == MASTER_CODE);
          CK_WRITE: begin
            ok_d  = len_ok;
            wr_en = len_ok;
          end
          default: ok_d = 1'b0;
        endcase
        buf_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = RESULT;
      end
      RESULT: begin
        state_d = (kind_q == CK_MASTER && ok_q) ? PROG_SEL : IDLE;
`ifdef LOCKOUT_EN
        if (kind_q == CK_USER && ok_q) begin
          fcnt_d = '0;
        end else if (!ok_q && (kind_q == CK_USER || kind_q == CK_MASTER)) begin
          fcnt_d = fcnt_inc;
          if (fcnt_inc >= FW'(MAX_FAIL)) begin
            state_d = LOCKOUT;
            lk_d    = LK_LAST;
          end
        end
`endif
      end
`ifdef LOCKOUT_EN
      LOCKOUT: begin
        if (lk_q == '0) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          lk_d = lk_q - 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (expired) begin
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= CK_USER;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ok_q    <= 1'b0;
      hit_q   <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
      for (int unsigned s = 0; s < SLOTS; s++) slot_q[s] <= INIT_CODES[s*BW +: BW];
`ifdef LOCKOUT_EN
      fcnt_q  <= '0;
      lk_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ok_q    <= ok_d;
      hit_q   <= hit_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      if (wr_en) slot_q[sel_q] <= buf_q;
`ifdef LOCKOUT_EN
      fcnt_q  <= fcnt_d;
      lk_q    <= lk_d;
`endif
    end
  end

endmodule

// File: tb/tb_multi_code_lock.sv
// Directed bench for multi_code_lock; pulse expectations are queued at ENTER and checked when pulses appear.
module tb_multi_code_lock;

  logic       hwclk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       unlock, fail, locked_out, prog_mode, prog_done, ready;
  logic [0:0] hit_slot;
  logic [2:0] digit_cnt;

  int unsigned cyc = 0;
  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        unl;
    logic        fl;
    logic        pd;
    logic [0:0]  hit;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  multi_code_lock #(
    .DIGITS(6),
    .SLOTS(2),
    .MASTER_CODE(24'h999999),
    .INIT_CODES({24'h666666, 24'h123456}),
    .MAX_FAIL(3),
    .LOCKOUT_CYCLES(100),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .hwclk(hwclk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .unlock(unlock),
    .hit_slot(hit_slot),
    .fail(fail),
    .locked_out(locked_out),
    .prog_mode(prog_mode),
    .prog_done(prog_done),
    .digit_cnt(digit_cnt),
    .ready(ready)
  );

  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    @(posedge hwclk);
    #1;
    key_valid = 1'b1;
    key_code  = k;
    @(posedge hwclk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic code(input logic [23:0] c);
    for (int i = 5; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  // Called right after the accepting edge: the pulse belongs to the cycle after the next edge.
  task automatic push_exp(input logic u, input logic f, input logic p, input logic [0:0] h);
    sb.push_back('{unl: u, fl: f, pd: p, hit: h, cyc: cyc + 1});
  endtask

  task automatic enter(input logic u, input logic f, input logic p, input logic [0:0] h);
    press(4'hB);
    push_exp(u, f, p, h);
    idle(3);
  endtask

  always @(negedge hwclk) begin
    if (!rst && (unlock || fail || prog_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({unlock, fail, prog_done}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", 32'({unlock, fail, prog_done}), 32'({mon_e.unl, mon_e.fl, mon_e.pd}));
        chk("pulse_cycle", cyc, mon_e.cyc);
        if (mon_e.unl) chk("hit_slot", 32'(hit_slot), 32'(mon_e.hit));
      end
    end
  end

  initial begin
    int unsigned c0;
    int n;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    idle(3);
    @(negedge hwclk);
    chk("reset_outputs", 32'({unlock, fail, locked_out, prog_mode, prog_done, hit_slot, digit_cnt, ready}),
        32'b0000_0000_1);
    @(posedge hwclk);
    #1 rst = 1'b0;
    idle(2);

    // both stored codes unlock, reporting their slot
    code(24'h123456);
    enter(1'b1, 1'b0, 1'b0, 1'b0);
    code(24'h666666);
    enter(1'b1, 1'b0, 1'b0, 1'b1);

    // short, overflowed and wrong entries
    press(4'h1); press(4'h2); press(4'h3);
    enter(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) press(4'(i));
    @(negedge hwclk);
    chk("overflow_cnt", 32'(digit_cnt), 32'd7);
    enter(1'b0, 1'b1, 1'b0, 1'b0);
    code(24'h000000);
`ifdef LOCKOUT_EN
    press(4'hB);
    c0 = cyc;
    push_exp(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    @(negedge hwclk);
    chk("lockout_on", 32'(locked_out), 32'd1);
    chk("lockout_ready", 32'(ready), 32'd0);
    code(24'h123456);
    press(4'hB);
    @(negedge hwclk);
    chk("lockout_keys_dropped", 32'(digit_cnt), 32'd0);
    chk("lockout_still_on", 32'(locked_out), 32'd1);
    n = 0;
    while (locked_out && n < 200) begin
      @(negedge hwclk);
      n++;
    end
    chk("lockout_length", cyc - c0, 32'd102);
    idle(1);
`else
    enter(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge hwclk);
    chk("no_lockout", 32'(locked_out), 32'd0);
`endif
    code(24'h123456);
    enter(1'b1, 1'b0, 1'b0, 1'b0);

    // program slot 1 with 777777
    press(4'hC);
    @(negedge hwclk);
    chk("prog_auth_mode", 32'(prog_mode), 32'd1);
    code(24'h999999);
    press(4'hB);
    idle(3);
    @(negedge hwclk);
    chk("prog_sel_mode", 32'({prog_mode, digit_cnt}), 32'b1000);
    press(4'h1);
    code(24'h777777);
    enter(1'b0, 1'b0, 1'b1, 1'b0);
    code(24'h777777);
    enter(1'b1, 1'b0, 1'b0, 1'b1);
    code(24'h666666);
    enter(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge hwclk);
    chk("hit_slot_held", 32'(hit_slot), 32'd1);
    code(24'h123456);
    enter(1'b1, 1'b0, 1'b0, 1'b0);

    // two counted failures, then an uncounted slot-select abort must not trip lockout
    code(24'h000000);
    enter(1'b0, 1'b1, 1'b0, 1'b0);
    code(24'h000001);
    enter(1'b0, 1'b1, 1'b0, 1'b0);
    press(4'hC);
    code(24'h999999);
    press(4'hB);
    idle(3);
    press(4'h5);
    push_exp(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    @(negedge hwclk);
    chk("abort_idle", 32'({prog_mode, digit_cnt, ready, locked_out}), 32'b0_000_1_0);
    code(24'h123456);
    enter(1'b1, 1'b0, 1'b0, 1'b0);

    // CLEAR from entry and from programming
    press(4'h1); press(4'h2); press(4'hA);
    @(negedge hwclk);
    chk("clear_entry", 32'({digit_cnt, ready}), 32'b000_1);
    press(4'hC); press(4'hA);
    @(negedge hwclk);
    chk("clear_prog", 32'(prog_mode), 32'd0);

    // inactivity timeout
    press(4'h1); press(4'h2); press(4'h3);
    repeat (45) @(negedge hwclk);
    chk("timeout_not_early", 32'(digit_cnt), 32'd3);
    repeat (7) @(negedge hwclk);
    chk("timeout_expired", 32'({digit_cnt, ready, prog_mode}), 32'b000_1_0);
    code(24'h123456);
    enter(1'b1, 1'b0, 1'b0, 1'b0);

    // reset in PROG_NEW restores the initial slot contents
    press(4'hC);
    code(24'h999999);
    press(4'hB);
    idle(3);
    press(4'h1); press(4'h8); press(4'h8);
    rst = 1'b1;
    idle(2);
    @(negedge hwclk);
    chk("reset_mid_prog", 32'({unlock, fail, locked_out, prog_mode, prog_done, hit_slot, digit_cnt, ready}),
        32'b0000_0000_1);
    @(posedge hwclk);
    #1 rst = 1'b0;
    idle(1);
    code(24'h666666);
    enter(1'b1, 1'b0, 1'b0, 1'b1);
    code(24'h777777);
    enter(1'b0, 1'b1, 1'b0, 1'b0);

    // reset in the CHECK cycle of a slot write discards the write
    press(4'hC);
    code(24'h999999);
    press(4'hB);
    idle(3);
    press(4'h0);
    code(24'h888888);
    press(4'hB);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    code(24'h888888);
    enter(1'b0, 1'b1, 1'b0, 1'b0);
    code(24'h123456);
    enter(1'b1, 1'b0, 1'b0, 1'b0);

    idle(5);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
